mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk in 1 system clock; rst in 1 asynchronous active-high reset.
REQ-002 SHALL have fetch requester ports: fetch_req in 1 level instruction-read request; fetch_addr in 16 read address; fetch_valid out 1 one-cycle response strobe; fetch_rdata out 16 instruction word; fetch_stall out 1 hold PC.
REQ-003 SHALL have data requester ports: data_rd in 1 load request; data_wr in 1 store request; data_addr in 16 address; data_wdata in 16 store data; data_valid out 1 one-cycle response strobe; data_rdata out 16 load data; data_stall out 1 hold pipeline.
REQ-004 SHALL have memory port: mem_req out 1 one-cycle issue strobe; mem_wr out 1 write qualifier; mem_addr out 16; mem_wdata out 16; mem_rdata in 16; mem_done in 1 completion strobe.
REQ-005 SHALL have halt in 1 (block new fetch grants) and err out 1 (sticky error).

Function
REQ-006 SHALL implement FSM states IDLE, WAIT_F, WAIT_D, RESP; one transaction outstanding at most.
REQ-007 In IDLE, with data request only -> WAIT_D; fetch request only (halt=0) -> WAIT_F; neither -> IDLE.
REQ-008 When both pending in IDLE, SHALL grant the requester not served last (last_grant bit); after reset, data wins first.
REQ-009 halt=1 SHALL suppress fetch grants only; data grants continue; an in-flight fetch completes normally.
REQ-010 On grant, SHALL latch address, write data and rd/wr into registers; mem_req high exactly first cycle of WAIT_x, mem_addr/mem_wr/mem_wdata driven from latches for whole WAIT_x.
REQ-011 mem_done in WAIT_x cycle N SHALL register mem_rdata into matching rdata output and pulse matching valid in cycle N+1 (state RESP); stores pulse data_valid, data_rdata unchanged.
REQ-012 mem_done in same cycle as mem_req SHALL be accepted (minimum latency 1, valid two cycles after grant decision).
REQ-013 RESP SHALL last one cycle, always return to IDLE; no grant decided in RESP, so requester may drop/change request after valid.
REQ-014 fetch_stall = fetch_req & ~fetch_valid; data_stall = (data_rd|data_wr) & ~data_valid; combinational.
REQ-015 mem_done in IDLE or RESP SHALL be ignored and set err.
REQ-016 data_rd & data_wr both high in IDLE SHALL set err; grant proceeds as write.
REQ-017 rdata outputs SHALL hold last value until next matching completion.
REQ-018 err SHALL be sticky until reset.

Reset
REQ-019 rst SHALL asynchronously force IDLE, last_grant=fetch, all latches, rdata outputs, valid strobes, mem_req, mem_wr, err to 0.
REQ-020 rst mid-transaction SHALL drop it; late mem_done after reset release sets err per REQ-015.

Configuration
REQ-021 With MEM_ARB_TIMEOUT_EN defined, SHALL count WAIT_x cycles; reaching MEM_ARB_TIMEOUT (64) without mem_done SHALL set err, pulse matching valid with rdata 16'h0000, enter RESP.
REQ-022 Without MEM_ARB_TIMEOUT_EN, no counter; WAIT_x held indefinitely.

Structure
REQ-023 State encodings, MEM_ARB_TIMEOUT and grant-encoding constants SHALL reside in shared header/package.
REQ-024 Timeout counter SHALL be sub-module mem_arb_timer (clear, enable, expired), instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-025 fetch_req, fetch_addr=16'h0010, mem_done 3 cycles after mem_req, mem_rdata=16'hA5A5 -> mem_addr=16'h0010, fetch_valid one cycle after mem_done, fetch_rdata=16'hA5A5, fetch_stall low that cycle.
REQ-026 fetch_req and data_rd concurrent from reset -> data granted first, then fetch; persisting both -> strict alternation D,F,D,F.
REQ-027 data_wr, data_addr=16'h0020, data_wdata=16'h1234 -> mem_req=1 with mem_wr=1, mem_wdata=16'h1234; data_valid pulse; data_rdata unchanged.
REQ-028 halt=1 with fetch_req and data_rd -> only data served; fetch_stall stays high; halt=0 -> fetch granted next IDLE.
REQ-029 Spurious mem_done in IDLE, and data_rd&data_wr together -> err=1, held until rst; rst in WAIT_D -> all outputs zero immediately.
REQ-030 With MEM_ARB_TIMEOUT_EN, no mem_done for 64 cycles -> err=1, valid pulse with rdata 16'h0000, FSM back to IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants for the fetch/data memory arbiter.
//   state_e          - arbiter FSM state encoding
//   grant_e          - encoding of the last requester served
//   MEM_ARB_TIMEOUT  - WAIT cycles before a stuck transaction is abandoned
//                      (used only when MEM_ARB_TIMEOUT_EN is defined)
//   TIMER_W          - width of the timeout counter
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StWaitF = 2'd1,
      StWaitD = 2'd2,
      StResp  = 2'd3
   } state_e;

   typedef enum logic {
      GrantFetch = 1'b0,
      GrantData  = 1'b1
   } grant_e;

   localparam int unsigned MEM_ARB_TIMEOUT = 64;
   localparam int unsigned TIMER_W         = $clog2(MEM_ARB_TIMEOUT + 1);

endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: counts cycles spent waiting on memory and flags expiry.
// Compiled only when MEM_ARB_TIMEOUT_EN is defined.
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - return the count to zero
//   enable    - count this cycle
//   expired   - high during the MEM_ARB_TIMEOUT-th enabled cycle
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_timer
   import mem_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [TIMER_W-1:0] cnt_q;

   assign expired = enable & (cnt_q == TIMER_W'(MEM_ARB_TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable && !expired) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule
`endif

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch requester
// and a load/store requester, one transaction outstanding at a time.
//   clk, rst                      - clock, asynchronous active-high reset
//   fetch_req/addr                - instruction read request (level)
//   fetch_valid/rdata/stall       - fetch response strobe, data, PC hold
//   data_rd/wr/addr/wdata         - load/store request (level)
//   data_valid/rdata/stall        - data response strobe, load data, hold
//   mem_req/wr/addr/wdata         - memory issue strobe and command
//   mem_rdata, mem_done           - memory read data and completion strobe
//   halt                          - block new fetch grants
//   err                           - sticky protocol error
// Optional: MEM_ARB_TIMEOUT_EN abandons a transaction after MEM_ARB_TIMEOUT
// WAIT cycles, flags err and returns zero read data.
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_req,
   input  logic [15:0] fetch_addr,
   output logic        fetch_valid,
   output logic [15:0] fetch_rdata,
   output logic        fetch_stall,
   input  logic        data_rd,
   input  logic        data_wr,
   input  logic [15:0] data_addr,
   input  logic [15:0] data_wdata,
   output logic        data_valid,
   output logic [15:0] data_rdata,
   output logic        data_stall,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_done,
   input  logic        halt,
   output logic        err
);

   state_e      state_q;
   grant_e      last_grant_q;
   logic [15:0] addr_q, wdata_q;
   logic        wr_q;
   logic        fetch_valid_q, data_valid_q, mem_req_q, err_q;
   logic [15:0] fetch_rdata_q, data_rdata_q;

   logic data_pend, fetch_pend, pick_data, timeout;

   assign data_pend  = data_rd | data_wr;
   assign fetch_pend = fetch_req & ~halt;
   // Data wins unless fetch is also eligible and data was the last one served.
   assign pick_data  = data_pend & (~fetch_pend | (last_grant_q == GrantFetch));

`ifdef MEM_ARB_TIMEOUT_EN
   logic waiting;
   assign waiting = (state_q == StWaitF) || (state_q == StWaitD);

   mem_arb_timer u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (~waiting),
      .enable  (waiting),
      .expired (timeout)
   );
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         last_grant_q  <= GrantFetch;
         addr_q        <= '0;
         wdata_q       <= '0;
         wr_q          <= 1'b0;
         fetch_valid_q <= 1'b0;
         data_valid_q  <= 1'b0;
         mem_req_q     <= 1'b0;
         err_q         <= 1'b0;
         fetch_rdata_q <= '0;
         data_rdata_q  <= '0;
      end else begin
         fetch_valid_q <= 1'b0;
         data_valid_q  <= 1'b0;
         mem_req_q     <= 1'b0;
         case (state_q)
            StIdle: begin
               if (mem_done || (data_rd && data_wr)) err_q <= 1'b1;
               if (pick_data) begin
                  addr_q       <= data_addr;
                  wdata_q      <= data_wdata;
                  wr_q         <= data_wr;  // rd+wr together proceeds as a write
                  mem_req_q    <= 1'b1;
                  last_grant_q <= GrantData;
                  state_q      <= StWaitD;
               end else if (fetch_pend) begin
                  addr_q       <= fetch_addr;
                  wdata_q      <= '0;
                  wr_q         <= 1'b0;
                  mem_req_q    <= 1'b1;
                  last_grant_q <= GrantFetch;
                  state_q      <= StWaitF;
               end
            end
            StWaitF, StWaitD: begin
               if (mem_done) begin
                  if (state_q == StWaitF) begin
                     fetch_valid_q <= 1'b1;
                     fetch_rdata_q <= mem_rdata;
                  end else begin
                     data_valid_q <= 1'b1;
                     if (!wr_q) data_rdata_q <= mem_rdata;
                  end
                  state_q <= StResp;
               end else if (timeout) begin
                  err_q <= 1'b1;
                  if (state_q == StWaitF) begin
                     fetch_valid_q <= 1'b1;
                     fetch_rdata_q <= '0;
                  end else begin
                     data_valid_q <= 1'b1;
                     data_rdata_q <= '0;
                  end
                  state_q <= StResp;
               end
            end
            StResp: begin
               if (mem_done) err_q <= 1'b1;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign fetch_valid = fetch_valid_q;
   assign fetch_rdata = fetch_rdata_q;
   assign data_valid  = data_valid_q;
   assign data_rdata  = data_rdata_q;
   assign mem_req     = mem_req_q;
   assign mem_wr      = wr_q;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign err         = err_q;

   assign fetch_stall = fetch_req & ~fetch_valid_q;
   assign data_stall  = data_pend & ~data_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. A transaction-level
// model predicts the winner of each arbitration (requester not served last,
// fetch ineligible while halted) and the values each response should carry.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        fetch_req = 1'b0, data_rd = 1'b0, data_wr = 1'b0, halt = 1'b0;
   logic [15:0] fetch_addr = '0, data_addr = '0, data_wdata = '0, mem_rdata = '0;
   logic        mem_done = 1'b0;
   logic        fetch_valid, fetch_stall, data_valid, data_stall;
   logic        mem_req, mem_wr, err;
   logic [15:0] fetch_rdata, data_rdata, mem_addr, mem_wdata;

   int checks = 0;
   int failures = 0;

   // Reference model state.
   bit          last_was_fetch;
   logic [15:0] exp_f_rdata, exp_d_rdata;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_valid (fetch_valid),
      .fetch_rdata (fetch_rdata),
      .fetch_stall (fetch_stall),
      .data_rd     (data_rd),
      .data_wr     (data_wr),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_valid  (data_valid),
      .data_rdata  (data_rdata),
      .data_stall  (data_stall),
      .mem_req     (mem_req),
      .mem_wr      (mem_wr),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_done    (mem_done),
      .halt        (halt),
      .err         (err)
   );

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      fetch_req = 1'b0; data_rd = 1'b0; data_wr = 1'b0; halt = 1'b0; mem_done = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      last_was_fetch = 1'b1;
      exp_f_rdata = '0;
      exp_d_rdata = '0;
   endtask

   // One complete transaction with requests held until the response.
   task automatic do_txn(input logic f, input logic rd, input logic wr, input logic h,
                         input logic [15:0] fa, input logic [15:0] da, input logic [15:0] wd,
                         input int lat, input logic [15:0] rdat);
      bit          win_data;
      int          n;
      logic [15:0] exp_addr;
      fetch_req = f; data_rd = rd; data_wr = wr; halt = h;
      fetch_addr = fa; data_addr = da; data_wdata = wd;
      win_data = (rd | wr) && (!(f && !h) || last_was_fetch);
      exp_addr = win_data ? da : fa;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (mem_req !== 1'b1 && n < 10);
      checks++;
      if (mem_req !== 1'b1) begin
         failures++;
         $display("FAIL grant_wait mem_req=%b after %0d cycles, required 1", mem_req, n);
         return;
      end
      checks++;
      if (mem_addr !== exp_addr) begin
         failures++;
         $display("FAIL mem_addr got=%h exp=%h", mem_addr, exp_addr);
      end
      checks++;
      if (mem_wr !== (win_data & wr)) begin
         failures++;
         $display("FAIL mem_wr got=%b exp=%b", mem_wr, win_data & wr);
      end
      if (win_data && wr) begin
         checks++;
         if (mem_wdata !== wd) begin
            failures++;
            $display("FAIL mem_wdata got=%h exp=%h", mem_wdata, wd);
         end
      end
      last_was_fetch = !win_data;
      for (int i = 0; i < lat; i++) begin
         @(negedge clk);
         checks++;
         if (mem_req !== 1'b0 || fetch_valid !== 1'b0 || data_valid !== 1'b0 ||
             mem_addr !== exp_addr) begin
            failures++;
            $display("FAIL wait_hold req=%b fv=%b dv=%b addr=%h exp req=0 fv=0 dv=0 addr=%h",
                     mem_req, fetch_valid, data_valid, mem_addr, exp_addr);
         end
      end
      mem_done = 1'b1;
      mem_rdata = rdat;
      @(negedge clk);
      mem_done = 1'b0;
      mem_rdata = 16'($urandom);
      if (win_data) begin
         if (!wr) exp_d_rdata = rdat;
      end else begin
         exp_f_rdata = rdat;
      end
      checks++;
      if (fetch_valid !== !win_data || data_valid !== win_data) begin
         failures++;
         $display("FAIL resp_valid fv=%b dv=%b exp fv=%b dv=%b",
                  fetch_valid, data_valid, !win_data, win_data);
      end
      checks++;
      if (fetch_rdata !== exp_f_rdata || data_rdata !== exp_d_rdata) begin
         failures++;
         $display("FAIL resp_rdata f=%h d=%h exp f=%h d=%h",
                  fetch_rdata, data_rdata, exp_f_rdata, exp_d_rdata);
      end
      checks++;
      if (fetch_stall !== (f & win_data) || data_stall !== ((rd | wr) & !win_data)) begin
         failures++;
         $display("FAIL resp_stall fs=%b ds=%b exp fs=%b ds=%b",
                  fetch_stall, data_stall, f & win_data, (rd | wr) & !win_data);
      end
      @(negedge clk);
      checks++;
      if (fetch_valid !== 1'b0 || data_valid !== 1'b0 || mem_req !== 1'b0) begin
         failures++;
         $display("FAIL resp_one_cycle fv=%b dv=%b req=%b exp all 0",
                  fetch_valid, data_valid, mem_req);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      fetch_req = 1'b1;
      #1;
      checks++;
      if ({fetch_valid, data_valid, mem_req, mem_wr, err} !== 5'b0 ||
          fetch_rdata !== 16'h0 || data_rdata !== 16'h0 ||
          mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
         failures++;
         $display("FAIL reset_outputs fv=%b dv=%b req=%b wr=%b err=%b fr=%h dr=%h a=%h wd=%h exp 0",
                  fetch_valid, data_valid, mem_req, mem_wr, err,
                  fetch_rdata, data_rdata, mem_addr, mem_wdata);
      end
      checks++;
      if (fetch_stall !== 1'b1 || data_stall !== 1'b0) begin
         failures++;
         $display("FAIL reset_stall fs=%b ds=%b exp fs=1 ds=0", fetch_stall, data_stall);
      end
      do_reset();
   endtask

   task automatic test_fetch_basic();
      do_txn(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 3, 16'hA5A5);
   endtask

   task automatic test_store();
      do_txn(1'b0, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0044, 16'h0000, 1, 16'h7E57);
      do_txn(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0020, 16'h1234, 2, 16'hDEAD);
   endtask

   task automatic test_alternation();
      do_reset();
      for (int i = 0; i < 4; i++)
         do_txn(1'b1, 1'b1, 1'b0, 1'b0, 16'h0100 + 16'(i), 16'h0200 + 16'(i), 16'h0,
                i, 16'h1000 + 16'(i));
   endtask

   task automatic test_halt();
      do_reset();
      do_txn(1'b1, 1'b1, 1'b0, 1'b1, 16'h0300, 16'h0400, 16'h0, 1, 16'h3333);
      do_txn(1'b1, 1'b1, 1'b0, 1'b1, 16'h0300, 16'h0404, 16'h0, 0, 16'h4444);
      do_txn(1'b1, 1'b1, 1'b0, 1'b0, 16'h0300, 16'h0408, 16'h0, 2, 16'h5555);
   endtask

   task automatic test_random();
      logic f, h;
      int   op;
      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 2);
         f  = 1'($urandom_range(0, 1));
         h  = ($urandom_range(0, 3) == 0);
         if (op == 0 && !(f && !h)) op = 1;
         do_txn(f, op == 1, op == 2, h, 16'($urandom), 16'($urandom), 16'($urandom),
                $urandom_range(0, 4), 16'($urandom));
      end
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL random_err err=%b exp=0", err);
      end
   endtask

   task automatic test_errors();
      do_reset();
      mem_done = 1'b1;
      @(negedge clk);
      mem_done = 1'b0;
      checks++;
      if (err !== 1'b1) begin
         failures++;
         $display("FAIL err_spurious err=%b exp=1", err);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (err !== 1'b1) begin
         failures++;
         $display("FAIL err_sticky err=%b exp=1", err);
      end
      do_reset();
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL err_cleared err=%b exp=0", err);
      end
      data_rd = 1'b1; data_wr = 1'b1; data_addr = 16'h0030; data_wdata = 16'h5555;
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_wdata !== 16'h5555) begin
         failures++;
         $display("FAIL rdwr_conflict err=%b req=%b wr=%b wd=%h exp 1 1 1 5555",
                  err, mem_req, mem_wr, mem_wdata);
      end
      // Now in WAIT_D: reset between clock edges must clear outputs at once.
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({mem_req, mem_wr, err, fetch_valid, data_valid} !== 5'b0 ||
          mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
         failures++;
         $display("FAIL async_reset req=%b wr=%b err=%b fv=%b dv=%b a=%h wd=%h exp 0",
                  mem_req, mem_wr, err, fetch_valid, data_valid, mem_addr, mem_wdata);
      end
      @(negedge clk);
      data_rd = 1'b0; data_wr = 1'b0; rst = 1'b0;
      last_was_fetch = 1'b1; exp_f_rdata = '0; exp_d_rdata = '0;
      mem_done = 1'b1;
      @(negedge clk);
      mem_done = 1'b0;
      checks++;
      if (err !== 1'b1) begin
         failures++;
         $display("FAIL late_done err=%b exp=1", err);
      end
   endtask

`ifdef MEM_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      do_reset();
      do_txn(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0050, 16'h0, 0, 16'hBEEF);
      data_rd = 1'b1; data_addr = 16'h0060;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (mem_req !== 1'b1 && n < 10);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (data_valid !== 1'b1 && n < 100);
      data_rd = 1'b0;
      checks++;
      if (n != 64 || data_rdata !== 16'h0000 || err !== 1'b1) begin
         failures++;
         $display("FAIL timeout cycles=%0d rdata=%h err=%b exp 64 0000 1", n, data_rdata, err);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (data_valid !== 1'b0 || mem_req !== 1'b0) begin
         failures++;
         $display("FAIL timeout_idle dv=%b req=%b exp 0 0", data_valid, mem_req);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_fetch_basic();
      test_store();
      test_alternation();
      test_halt();
      test_random();
      test_errors();
`ifdef MEM_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
